// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: Moore control FSM that steps the FIR MAC datapath through
// load, clear, one MAC per tap and a result strobe, with a sticky overrun flag.
`default_nettype none

module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= (count_out == rollover_val) ? '0 : count_out + 1'b1;
    end
  end

  assign rollover_flag = (count_out == rollover_val);

endmodule

module fir_tap_sequencer #(
  parameter int NUM_TAPS = 4,
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                sample_valid,
  input  logic                abort,
  input  logic                clear_err,
  output logic                sample_ready,
  output logic                load_sample,
  output logic                acc_clear,
  output logic                mac_en,
  output logic [CNT_BITS-1:0] tap_idx,
  output logic                result_valid,
  output logic                busy,
  output logic                err
);

  localparam logic [CNT_BITS-1:0] LAST_TAP = CNT_BITS'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CLR  = 3'd2,
    MAC  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state;
  state_t next_state;
  logic   cnt_clear;
  logic   cnt_enable;
  logic   rollover;

  flex_counter #(
    .NUM_CNT_BITS(CNT_BITS)
  ) u_tap_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_enable),
    .rollover_val (LAST_TAP),
    .count_out    (tap_idx),
    .rollover_flag(rollover)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    sample_ready = 1'b0;
    load_sample  = 1'b0;
    acc_clear    = 1'b0;
    mac_en       = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;
    case (state)
      IDLE: begin
        busy         = 1'b0;
        sample_ready = 1'b1;
        if (sample_valid) next_state = LOAD;
      end
      LOAD: begin
        load_sample = 1'b1;
        next_state  = CLR;
      end
      CLR: begin
        acc_clear  = 1'b1;
        cnt_clear  = 1'b1;
        next_state = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        // Hold on the last tap so DONE still shows NUM_TAPS-1.
        cnt_enable = !rollover;
        if (rollover) next_state = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        cnt_clear    = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      next_state = IDLE;
      cnt_clear  = 1'b1;
    end
  end

  // Set has priority over clear so a simultaneous overrun is never lost.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err <= 1'b0;
    end else if (sample_valid && busy) begin
      err <= 1'b1;
    end else if (clear_err) begin
      err <= 1'b0;
    end
  end

endmodule

`default_nettype wire
